// File: rtl/rst_seq_if.sv
// Register-bus bundle for the reset sequencer: strobe/write/select/data in, read data and ack out.
interface rst_seq_if;
  logic        stb;
  logic        we;
  logic        addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;

  modport master (output stb, we, addr, data_in, input data_out, ack);
  modport slave  (input stb, we, addr, data_in, output data_out, ack);
endinterface

// File: rtl/rst_seq.sv
// Reset sequencer: holds rst_out for ASSERT_CYCLES, then ignores requests for SETTLE_CYCLES.
// Trigger at edge k gives rst_out in cycles k+1..k+ASSERT_CYCLES; bus ack is combinational (never stalls).
module rst_seq #(
  parameter int ASSERT_CYCLES = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] rst_req_in,
  rst_seq_if.slave   bus,
  output logic       rst_out,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SETTLE} state_e;

  localparam logic [7:0] A_LAST = 8'(ASSERT_CYCLES - 1);
  localparam logic [7:0] S_LAST = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] cause_q, cause_d;
  logic [7:0] rst_cnt_q, rst_cnt_d;

  logic       sw_req;
  logic       wr0;
  logic       rd0;
  logic [3:0] trig;
  logic       unused_data_bits;

  assign sw_req = bus.stb & bus.we & bus.addr & bus.data_in[0];
  assign wr0    = bus.stb & bus.we & ~bus.addr;
  assign rd0    = bus.stb & ~bus.we & ~bus.addr;
  assign trig   = {sw_req, rst_req_in} & mask_q;
  assign unused_data_bits = ^{bus.data_in[31:9], bus.data_in[7:4]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_ASSERT;
      cnt_q     <= '0;
      mask_q    <= 4'hF;
      cause_q   <= '0;
      rst_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      cause_q   <= cause_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    cause_d   = cause_q;
    rst_cnt_d = rst_cnt_q;

    // Register writes land in any state; a trigger in the same cycle still sees the old mask.
    if (wr0) begin
      mask_d = bus.data_in[3:0];
      if (bus.data_in[8]) begin
        cause_d   = '0;
        rst_cnt_d = '0;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (trig != 4'b0) begin
          state_d = S_ASSERT;
          cnt_d   = '0;
          cause_d = trig;
          if (rst_cnt_q != 8'hFF) rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end
      S_ASSERT: begin
        if (cnt_q == A_LAST) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == S_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rst_out      = (state_q == S_ASSERT);
  assign busy         = (state_q != S_IDLE);
  assign bus.ack      = bus.stb;
  assign bus.data_out = rd0 ? {16'b0, rst_cnt_q, cause_q, mask_q} : 32'b0;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: register table, directed multi-cycle sequences, then random traffic vs a remaining-cycles model.
module tb_rst_seq;
  localparam int A = 16;
  localparam int S = 8;

  logic       clk;
  logic       rst;
  logic [2:0] rst_req_in;
  logic       rst_out;
  logic       busy;

  rst_seq_if bus ();

  rst_seq #(.ASSERT_CYCLES(A), .SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .rst_req_in (rst_req_in),
    .bus        (bus.slave),
    .rst_out    (rst_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: cycles of busy remaining; rst_out while more than S remain.
  int         m_left  = A + S;
  logic [3:0] m_mask  = 4'hF;
  logic [3:0] m_cause = 4'h0;
  int         m_cnt   = 0;
  logic [31:0] tb_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic s, input logic w, input logic a);
    if (s && !w && !a) return {16'b0, 8'(m_cnt), m_cause, m_mask};
    return 32'b0;
  endfunction

  task automatic model_edge(input logic r, input logic [2:0] req, input logic s, input logic w,
                            input logic a, input logic [31:0] d);
    logic [3:0] t;
    if (r) begin
      m_left = A + S; m_mask = 4'hF; m_cause = 4'h0; m_cnt = 0;
    end else begin
      t = {s & w & a & d[0], req} & m_mask;
      if (s && w && !a) begin
        m_mask = d[3:0];
        if (d[8]) begin m_cause = 4'h0; m_cnt = 0; end
      end
      if (m_left == 0) begin
        if (t != 4'h0) begin
          m_left  = A + S;
          m_cause = t;
          if (m_cnt < 255) m_cnt = m_cnt + 1;
        end
      end else begin
        m_left = m_left - 1;
      end
    end
  endtask

  // Called just after a rising edge: drive, check combinational bus outputs, clock, check registered outputs.
  task automatic step(input logic r, input logic [2:0] req, input logic s, input logic w,
                      input logic a, input logic [31:0] d);
    rst = r; rst_req_in = req;
    bus.stb = s; bus.we = w; bus.addr = a; bus.data_in = d;
    #1;
    tb_dout = bus.data_out;
    chk("ack", 32'(bus.ack), 32'(s));
    chk("data_out", bus.data_out, m_read(s, w, a));
    @(posedge clk);
    model_edge(r, req, s, w, a, d);
    #1;
    chk("rst_out", 32'(rst_out), 32'(m_left > S));
    chk("busy", 32'(busy), 32'(m_left != 0));
  endtask

  task automatic idle();
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rd0();
    step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic wr(input logic a, input logic [31:0] d);
    step(1'b0, 3'b000, 1'b1, 1'b1, a, d);
  endtask

  // Counts rst_out/busy cycles from the current cycle until the sequencer goes idle.
  task automatic run_seq(output int n_rst, output int n_busy);
    n_rst = 0; n_busy = 0;
    for (int k = 0; k < 400 && busy; k++) begin
      if (rst_out) n_rst++;
      n_busy++;
      idle();
    end
    chk("seq_reaches_idle", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic        addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic [31:0] exp_reg;
  } vec_t;

  vec_t vecs[6];

  int nr, nb, idle_cnt, rises;
  logic prev_busy;
  logic [2:0] rq;
  logic rs, rw, ra, rr;
  logic [31:0] rd;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0,   32'h0000000F, 32'h0000000F};
    vecs[1] = '{1'b0, 1'b1, 32'h0,   32'h00000000, 32'h0000000F};
    vecs[2] = '{1'b1, 1'b0, 32'h5,   32'h00000000, 32'h00000005};
    vecs[3] = '{1'b1, 1'b1, 32'h0,   32'h00000000, 32'h00000005};
    vecs[4] = '{1'b1, 1'b0, 32'h1F0, 32'h00000000, 32'h00000000};
    vecs[5] = '{1'b1, 1'b0, 32'h10F, 32'h00000000, 32'h0000000F};

    rst = 1'b1; rst_req_in = 3'b0;
    bus.stb = 1'b0; bus.we = 1'b0; bus.addr = 1'b0; bus.data_in = 32'h0;
    @(posedge clk); #1;

    // Power-on: three reset cycles, then a full sequence.
    step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("por_rst_out", 32'(rst_out), 32'd1);
    run_seq(nr, nb);
    chk("por_rst_cycles", 32'(nr), 32'd16);
    chk("por_busy_cycles", 32'(nb), 32'd24);
    rd0();
    chk("por_status", tb_dout, 32'h0000000F);

    // Register access table, all in IDLE with no requests.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 3'b000, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].din);
      chk("tbl_dout", tb_dout, vecs[i].exp_dout);
      chk("tbl_busy", 32'(busy), 32'd0);
      rd0();
      chk("tbl_reg", tb_dout, vecs[i].exp_reg);
    end

    // Watchdog one-cycle pulse.
    step(1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wd_first", 32'(rst_out), 32'd1);
    run_seq(nr, nb);
    chk("wd_rst_cycles", 32'(nr), 32'd16);
    chk("wd_busy_cycles", 32'(nb), 32'd24);
    rd0();
    chk("wd_status", tb_dout, 32'h0000012F);

    // Masked sysctrl request is ignored; watchdog still fires.
    wr(1'b0, 32'h0000000E);
    step(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("mask_busy0", 32'(busy), 32'd0);
    idle();
    chk("mask_busy1", 32'(busy), 32'd0);
    step(1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0);
    run_seq(nr, nb);
    chk("mask_rst_cycles", 32'(nr), 32'd16);
    rd0();
    chk("mask_status", tb_dout, 32'h0000022E);

    // Software + button together; a second software reset during SETTLE is dropped.
    wr(1'b0, 32'h0000000F);
    step(1'b0, 3'b100, 1'b1, 1'b1, 1'b1, 32'h1);
    rd0();
    chk("sw_status", tb_dout, 32'h000003CF);
    for (int i = 0; i < 15; i++) idle();
    chk("sw_in_settle", 32'({rst_out, busy}), 32'b01);
    step(1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 32'h1);
    run_seq(nr, nb);
    chk("sw_settle_rst", 32'(nr), 32'd0);
    chk("sw_settle_busy", 32'(nb), 32'd7);
    idle();
    chk("sw_ignored", 32'(busy), 32'd0);
    rd0();
    chk("sw_status2", tb_dout, 32'h000003CF);

    // Stuck button: back-to-back sequences with one idle cycle, count saturates.
    idle_cnt = 0; rises = 0; prev_busy = busy;
    for (int i = 0; i < 300 * (A + S + 1); i++) begin
      step(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 32'h0);
      if (!busy) idle_cnt++;
      if (busy && !prev_busy) rises++;
      prev_busy = busy;
    end
    chk("stuck_idle_cycles", 32'(idle_cnt), 32'd300);
    chk("stuck_sequences", 32'(rises), 32'd300);
    rd0();
    chk("stuck_status", tb_dout, 32'h0000FF4F);
    wr(1'b0, 32'h0000010F);
    rd0();
    chk("clear_status", tb_dout, 32'h0000000F);

    // Reset asserted at ASSERT counter 5 restarts a full sequence and restores the mask.
    wr(1'b0, 32'h00000007);
    step(1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) idle();
    step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    run_seq(nr, nb);
    chk("mid_rst_cycles", 32'(nr), 32'd16);
    chk("mid_busy_cycles", 32'(nb), 32'd24);
    rd0();
    chk("mid_status", tb_dout, 32'h0000000F);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 99) == 0);
      rq = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      rs = ($urandom_range(0, 3) == 0);
      rw = 1'($urandom);
      ra = 1'($urandom);
      rd = $urandom();
      if (rs && rw && !ra && rd[8]) rq = 3'b000;
      step(rr, rq, rs, rw, ra, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
